sim_run_sequencer: RTL
======================

Name: sim_run_sequencer

Overview:
- Synthesizable run controller for the fuzzing/IFT simulation top.
- Sequences the harness reset, counts run cycles and gates the waveform-dump window.
- Detects pass on tohost[0] and enforces a cycle timeout.
- When a variant harness is present, requires main and variant to finish in lockstep with identical tohost values. Any violation is reported as a failure.

Parameters:
- RESET_CYCLES, 16: cycles harness_reset is held after reset deasserts; legal range >= 1.
- HAS_VARIANT, 1: 1 = variant harness present and checked; 0 = tohost_var ignored.
- SYNC_WINDOW, 64: maximum cycles allowed between main and variant tohost events; legal range >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cfg_max_cycles  in  64  timeout limit; 0 = no timeout
- cfg_dump_start  in  64  cycle_count at which dumping starts
- cfg_dump_len  in  64  dump window length; 0 = dump until the run ends
- pause  in  1  debug/JTAG hold; freezes all counting and checks
- tohost_main  in  64  main harness tohost
- tohost_var  in  64  variant harness tohost
- harness_reset  out  1  reset driven to both harnesses
- dump_en  out  1  waveform dump enable
- cycle_count  out  64  run cycles elapsed
- done  out  1  run finished
- pass  out  1  run passed (valid when done)
- fail_code  out  2  0 none, 1 timeout, 2 sync timeout, 3 divergence
- state  out  3  0 RST_HOLD, 1 RUN, 2 WAIT_PEER, 3 PASS, 4 FAIL

Behaviour:
- Reset values: state=RST_HOLD, hold_cnt=0, win_cnt=0, cycle_count=0, harness_reset=1, dump_en=0, done=0, pass=0, fail_code=0. Reset mid-run aborts immediately and restarts the whole sequence.
- All outputs are registered.
- RST_HOLD: hold_cnt increments every cycle. When hold_cnt==RESET_CYCLES-1, go to RUN. harness_reset is 1 for exactly RESET_CYCLES cycles after reset falls and reads 0 on the first RUN cycle. cfg_* inputs are captured into shadow registers on this transition; later changes are ignored until the next reset.
- cycle_count increments by 1 per cycle in RUN and WAIT_PEER while pause==0, and saturates at 2^64-1. It holds its value in terminal states.
- Timeout: in RUN or WAIT_PEER with pause==0, if max!=0 and cycle_count >= max, go to FAIL with code 1. Timeout has priority over any tohost event in the same cycle.
- tohost event: bit[0]==1 on a given side. Events are sampled only in RUN or WAIT_PEER with pause==0.
- RUN, HAS_VARIANT=0: a main event goes to PASS.
- RUN, HAS_VARIANT=1, both sides fire in the same cycle: equal 64-bit values go to PASS; unequal values go to FAIL with code 3.
- RUN, HAS_VARIANT=1, one side fires: latch that side's value and which side fired, clear win_cnt, go to WAIT_PEER.
- WAIT_PEER: win_cnt increments while pause==0.
  - Peer event: compare with the latched value. Equal goes to PASS; unequal goes to FAIL with code 3.
  - A further event from the already-fired side is ignored.
  - If win_cnt reaches SYNC_WINDOW-1 with no peer event: go to FAIL with code 2. A peer event in that same cycle wins.
- pause=1: state, cycle_count and win_cnt are frozen; tohost is ignored; dump_en holds its value.
- dump_en:
  - Is 1 in RST_HOLD only when dump_start==0; the check uses the live cfg_dump_start value.
  - In RUN or WAIT_PEER, is 1 iff cycle_count >= start and (len==0 or cycle_count < start+len). The sum is 65 bits wide; no wrap.
  - Evaluation uses the next cycle_count value, so dump_en changes in the same cycle as the count reaches start.
  - Forced to 0 on entry to PASS or FAIL.
- PASS/FAIL are sticky until reset, with done=1 and harness_reset=0.
  - PASS: pass=1, fail_code=0.
  - FAIL: pass=0, fail_code holds the reason.

Test Plan:
- RESET_CYCLES=16, release reset -> harness_reset=1 for 16 cycles, state=1 on cycle 17, cycle_count=0 then increments to 1.
- HAS_VARIANT=1, tohost_main=tohost_var=0x1 at cycle 100 -> PASS, done=1, pass=1, cycle_count frozen at 100.
- tohost_main=0x1 at cycle 50, tohost_var=0x3 at cycle 60 -> WAIT_PEER, then FAIL with fail_code=3. A variant event with no main event for 64 cycles -> FAIL with fail_code=2 at win_cnt=63.
- max=1000, no tohost, pause high for cycles 200-299 -> timeout FAIL occurs 100 cycles later than it would without the pause; tohost_main=1 in the timeout cycle still gives fail_code=1.
- dump_start=10, len=5 -> dump_en high exactly while cycle_count is 10..14. dump_start=0 -> dump_en high through RST_HOLD.
- Assert reset while in WAIT_PEER -> all outputs return to reset values next cycle, and the sequence replays from RST_HOLD.

Source files
------------

// File: rtl/sim_run_sequencer.sv
// Run controller for the fuzzing/IFT simulation top: holds the harness in
// reset, counts run cycles, gates the waveform dump window, detects
// pass/timeout and checks that main and variant harnesses finish in lockstep.
module sim_run_sequencer #(
   parameter int RESET_CYCLES = 16,
   parameter bit HAS_VARIANT  = 1'b1,
   parameter int SYNC_WINDOW  = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] cfg_max_cycles,
   input  logic [63:0] cfg_dump_start,
   input  logic [63:0] cfg_dump_len,
   input  logic        pause,
   input  logic [63:0] tohost_main,
   input  logic [63:0] tohost_var,
   output logic        harness_reset,
   output logic        dump_en,
   output logic [63:0] cycle_count,
   output logic        done,
   output logic        pass,
   output logic [1:0]  fail_code,
   output logic [2:0]  state
);

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int WIN_W  = (SYNC_WINDOW > 1) ? $clog2(SYNC_WINDOW) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SYNC_WINDOW - 1);

   typedef enum logic [2:0] {
      ST_RST_HOLD  = 3'd0,
      ST_RUN       = 3'd1,
      ST_WAIT_PEER = 3'd2,
      ST_PASS      = 3'd3,
      ST_FAIL      = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
   logic [63:0]       cycle_count_q, cycle_count_d;
   logic              harness_reset_q, harness_reset_d;
   logic              dump_en_q, dump_en_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [1:0]        fail_code_q, fail_code_d;
   // configuration frozen at the start of the run
   logic [63:0]       max_q, max_d;
   logic [63:0]       start_q, start_d;
   logic [63:0]       len_q, len_d;
   // first tohost seen while waiting for the other harness
   logic [63:0]       lat_val_q, lat_val_d;
   logic              lat_main_q, lat_main_d;

   logic [63:0] cnt_inc;
   logic        ev_main, ev_var, ev_peer, timeout;
   logic [63:0] peer_val;

   // dump window test; the end bound is 65 bits so start+len never wraps
   function automatic logic in_window(input logic [63:0] cnt,
                                      input logic [63:0] start,
                                      input logic [63:0] len);
      logic [64:0] stop;
      stop = {1'b0, start} + {1'b0, len};
      return (cnt >= start) && ((len == 64'd0) || ({1'b0, cnt} < stop));
   endfunction

   // next-state, counters and registered-output values
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      win_cnt_d   = win_cnt_q;
      cycle_count_d = cycle_count_q;
      dump_en_d   = dump_en_q;
      fail_code_d = fail_code_q;
      max_d       = max_q;
      start_d     = start_q;
      len_d       = len_q;
      lat_val_d   = lat_val_q;
      lat_main_d  = lat_main_q;

      cnt_inc  = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 64'd1;
      ev_main  = tohost_main[0];
      ev_var   = HAS_VARIANT && tohost_var[0];
      timeout  = (max_q != 64'd0) && (cycle_count_q >= max_q);
      ev_peer  = lat_main_q ? ev_var : ev_main;
      peer_val = lat_main_q ? tohost_var : tohost_main;

      unique case (state_q)
         ST_RST_HOLD: begin
            if (!pause) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d   = ST_RUN;
                  max_d     = cfg_max_cycles;
                  start_d   = cfg_dump_start;
                  len_d     = cfg_dump_len;
                  dump_en_d = in_window(cycle_count_q, cfg_dump_start, cfg_dump_len);
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                  dump_en_d  = (cfg_dump_start == 64'd0);
               end
            end
         end
         ST_RUN, ST_WAIT_PEER: begin
            if (!pause) begin
               cycle_count_d = cnt_inc;
               dump_en_d     = in_window(cnt_inc, start_q, len_q);
               win_cnt_d     = win_cnt_q + WIN_W'(1);
               if (timeout) begin
                  state_d     = ST_FAIL;
                  fail_code_d = 2'd1;
               end else if (state_q == ST_RUN) begin
                  if (!HAS_VARIANT) begin
                     if (ev_main) state_d = ST_PASS;
                  end else if (ev_main && ev_var) begin
                     if (tohost_main == tohost_var) begin
                        state_d = ST_PASS;
                     end else begin
                        state_d     = ST_FAIL;
                        fail_code_d = 2'd3;
                     end
                  end else if (ev_main || ev_var) begin
                     state_d    = ST_WAIT_PEER;
                     lat_main_d = ev_main;
                     lat_val_d  = ev_main ? tohost_main : tohost_var;
                     win_cnt_d  = '0;
                  end
               end else begin
                  // a repeat from the side that already fired is ignored
                  if (ev_peer) begin
                     if (peer_val == lat_val_q) begin
                        state_d = ST_PASS;
                     end else begin
                        state_d     = ST_FAIL;
                        fail_code_d = 2'd3;
                     end
                  end else if (win_cnt_q == WIN_LAST) begin
                     state_d     = ST_FAIL;
                     fail_code_d = 2'd2;
                  end
               end
            end
         end
         default: ;
      endcase

      if (state_d == ST_PASS || state_d == ST_FAIL) dump_en_d = 1'b0;
      if (state_d == ST_PASS) fail_code_d = 2'd0;
      harness_reset_d = (state_d == ST_RST_HOLD);
      done_d          = (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass_d          = (state_d == ST_PASS);
   end

   // state and output registers; reset restarts the whole sequence
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_RST_HOLD;
         hold_cnt_q      <= '0;
         win_cnt_q       <= '0;
         cycle_count_q   <= '0;
         harness_reset_q <= 1'b1;
         dump_en_q       <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         fail_code_q     <= 2'd0;
         max_q           <= '0;
         start_q         <= '0;
         len_q           <= '0;
         lat_val_q       <= '0;
         lat_main_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         hold_cnt_q      <= hold_cnt_d;
         win_cnt_q       <= win_cnt_d;
         cycle_count_q   <= cycle_count_d;
         harness_reset_q <= harness_reset_d;
         dump_en_q       <= dump_en_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
         fail_code_q     <= fail_code_d;
         max_q           <= max_d;
         start_q         <= start_d;
         len_q           <= len_d;
         lat_val_q       <= lat_val_d;
         lat_main_q      <= lat_main_d;
      end
   end

   assign harness_reset = harness_reset_q;
   assign dump_en       = dump_en_q;
   assign cycle_count   = cycle_count_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign fail_code     = fail_code_q;
   assign state         = state_q;

endmodule
